wb_port_arbiter: RTL

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/pkg_parameters.sv | 14 +
 rtl/wb_port_arbiter_if.sv | 24 ++
 rtl/rr_arbiter2.sv | 34 +++
 rtl/wb_port_arbiter.sv | 68 ++++++
 4 files changed

// File: rtl/pkg_parameters.sv
// Shared widths and the write-port payload type for the writeback arbiter.
package pkg_parameters;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned NUM_WB_REQ     = 2;

  // One writeback request as seen by the register-file write port.
  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [XLEN-1:0]           data;
  } wb_req_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Request-side bundle: per-requester valid/ready handshake with address and data.
interface wb_port_arbiter_if;
  import pkg_parameters::*;

  logic [NUM_WB_REQ-1:0]                     req_valid;
  logic [NUM_WB_REQ-1:0]                     req_ready;
  logic [NUM_WB_REQ-1:0][REG_ADDR_WIDTH-1:0] req_addr;
  logic [NUM_WB_REQ-1:0][XLEN-1:0]           req_data;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with a one-bit pointer toward the favoured requester.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  input  logic       hold,
  output logic [1:0] grant_c
);

  logic rr_ptr;

  // Combinational one-hot grant; suppressed during hold and reset.
  always_comb begin
    grant_c = 2'b00;
    if (!rst && !hold) begin
      case (req_valid)
        2'b01:   grant_c = 2'b01;
        2'b10:   grant_c = 2'b10;
        2'b11:   grant_c = rr_ptr ? 2'b10 : 2'b01;
        default: grant_c = 2'b00;
      endcase
    end
  end

  // Pointer moves to the requester that lost (or was idle) after any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (|grant_c) begin
      rr_ptr <= grant_c[0];
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: selects one of two requesters per cycle, registers the
// register-file write, and forwards the pending write onto the rs read ports.
module wb_port_arbiter
  import pkg_parameters::*;
#(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  wb_port_arbiter_if.slave                     wb,
  input  logic                                 wb_hold,
  output logic                                 rd_web,
  output logic [REG_ADDR_WIDTH-1:0]            rd_addr,
  output logic [XLEN-1:0]                      rd_data,
  input  logic [NUM_WB_REQ-1:0][REG_ADDR_WIDTH-1:0] rs_addr,
  input  logic [NUM_WB_REQ-1:0][XLEN-1:0]      rs_rf_data,
  output logic [NUM_WB_REQ-1:0][XLEN-1:0]      rs_data
);

  logic [1:0] grant_c;
  wb_req_t    sel_c;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_valid (wb.req_valid),
    .hold      (wb_hold),
    .grant_c   (grant_c)
  );

  assign wb.req_ready = grant_c;

  // Payload of the granted requester.
  always_comb begin
    sel_c.addr = wb.req_addr[0];
    sel_c.data = wb.req_data[0];
    if (grant_c[1]) begin
      sel_c.addr = wb.req_addr[1];
      sel_c.data = wb.req_data[1];
    end
  end

  // Write stage: one-cycle latency; x0 writes are consumed without a strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_web  <= 1'b0;
      rd_addr <= '0;
      rd_data <= '0;
    end else begin
      rd_web <= (|grant_c) && (sel_c.addr != '0);
      if (|grant_c) begin
        rd_addr <= sel_c.addr;
        rd_data <= sel_c.data;
      end
    end
  end

  // Bypass: each read port independently picks up the pending write on a match.
  always_comb begin
    rs_data = rs_rf_data;
    for (int unsigned k = 0; k < NUM_WB_REQ; k++) begin
      if (BYPASS_EN && rd_web && (rs_addr[k] != '0) && (rs_addr[k] == rd_addr)) begin
        rs_data[k] = rd_data;
      end
    end
  end

endmodule
